// File: rtl/axi_dma_controller_axi_checker_if.sv
// rtl/axi_dma_controller_axi_checker_if.sv - AXI4 master-port bundle observed by the protocol checker
interface axi_dma_controller_axi_if #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32
);
   localparam int STRB_WD = DATA_WD / 8;

   logic [ADDR_WD-1:0] araddr;
   logic [7:0]         arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;
   logic               arvalid;
   logic               arready;

   logic [ADDR_WD-1:0] awaddr;
   logic [7:0]         awlen;
   logic [2:0]         awsize;
   logic [1:0]         awburst;
   logic               awvalid;
   logic               awready;

   logic [DATA_WD-1:0] wdata;
   logic [STRB_WD-1:0] wstrb;
   logic               wlast;
   logic               wvalid;
   logic               wready;

   logic [DATA_WD-1:0] rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic               rvalid;
   logic               rready;

   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;

   modport mon (
      input araddr, arlen, arsize, arburst, arvalid, arready,
      input awaddr, awlen, awsize, awburst, awvalid, awready,
      input wdata, wstrb, wlast, wvalid, wready,
      input rdata, rresp, rlast, rvalid, rready,
      input bresp, bvalid, bready
   );
endinterface

// File: rtl/axi_dma_controller_axi_checker.sv
// rtl/axi_dma_controller_axi_checker.sv - passive AXI4 handshake-stability and burst-accounting checker
// Never drives the bus; reports sticky per-rule flags, first violation, error-cycle count and depths.
module axi_dma_controller_axi_checker #(
   parameter  int ADDR_WD         = 32,
   parameter  int DATA_WD         = 32,
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int ERR_CNT_WD      = 16,
   localparam int CNT_WD          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_dma_controller_axi_if.mon axi,
   input  logic                  err_clr,
   output logic [7:0]            err_sticky,
   output logic                  err_first_valid,
   output logic [2:0]            err_first,
   output logic [ERR_CNT_WD-1:0] err_count,
   output logic [CNT_WD-1:0]     rd_outstanding,
   output logic [CNT_WD-1:0]     wr_outstanding,
   output logic [CNT_WD-1:0]     b_pending
);
   localparam int STRB_WD = DATA_WD / 8;
   localparam int AX_WD   = ADDR_WD + 13;
   localparam int W_WD    = DATA_WD + STRB_WD + 1;
   localparam int R_WD    = DATA_WD + 3;
   localparam int PTR_WD  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [AX_WD-1:0]      r_ar_copy, r_aw_copy;
   logic [W_WD-1:0]       r_w_copy;
   logic [R_WD-1:0]       r_r_copy;
   logic [1:0]            r_b_copy;
   logic                  r_ar_hold, r_aw_hold, r_w_hold, r_r_hold, r_b_hold;
   logic [7:0]            r_rd_len [MAX_OUTSTANDING];
   logic [7:0]            r_wr_len [MAX_OUTSTANDING];
   logic [PTR_WD-1:0]     r_rd_wp, r_rd_rp, r_wr_wp, r_wr_rp;
   logic [CNT_WD-1:0]     r_rd_cnt, r_wr_cnt, r_b_cnt;
   logic [7:0]            r_rbeat, r_wbeat;
   logic [7:0]            r_err_sticky;
   logic [ERR_CNT_WD-1:0] r_err_cnt;
   logic [2:0]            r_err_first;
   logic                  r_err_fv;

   logic [AX_WD-1:0] w_ar_pl, w_aw_pl;
   logic [W_WD-1:0]  w_w_pl;
   logic [R_WD-1:0]  w_r_pl;
   logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
   logic w_rd_empty, w_rd_full, w_rd_exp_last, w_rd_pop, w_rd_push;
   logic w_wr_empty, w_wr_full, w_wr_exp_last, w_wr_pop, w_wr_push;
   logic w_b_dec, w_any;
   logic [7:0] w_new_err;
   logic [2:0] w_first_idx;

   function automatic logic [PTR_WD-1:0] next_ptr(input logic [PTR_WD-1:0] p);
      return (p == PTR_WD'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_WD'(1);
   endfunction

   assign w_ar_pl = {axi.araddr, axi.arlen, axi.arsize, axi.arburst};
   assign w_aw_pl = {axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
   assign w_w_pl  = {axi.wdata, axi.wstrb, axi.wlast};
   assign w_r_pl  = {axi.rdata, axi.rresp, axi.rlast};

   assign w_ar_hs = axi.arvalid && axi.arready;
   assign w_aw_hs = axi.awvalid && axi.awready;
   assign w_w_hs  = axi.wvalid && axi.wready;
   assign w_r_hs  = axi.rvalid && axi.rready;
   assign w_b_hs  = axi.bvalid && axi.bready;

   // A burst ends on either rlast or the expected last beat, so a bad rlast resynchronises.
   assign w_rd_empty    = (r_rd_cnt == '0);
   assign w_rd_full     = (r_rd_cnt == CNT_WD'(MAX_OUTSTANDING));
   assign w_rd_exp_last = (r_rbeat == r_rd_len[r_rd_rp]);
   assign w_rd_pop      = w_r_hs && !w_rd_empty && (axi.rlast || w_rd_exp_last);
   assign w_rd_push     = w_ar_hs && (!w_rd_full || w_rd_pop);

   assign w_wr_empty    = (r_wr_cnt == '0);
   assign w_wr_full     = (r_wr_cnt == CNT_WD'(MAX_OUTSTANDING));
   assign w_wr_exp_last = (r_wbeat == r_wr_len[r_wr_rp]);
   assign w_wr_pop      = w_w_hs && !w_wr_empty && (axi.wlast || w_wr_exp_last);
   assign w_wr_push     = w_aw_hs && (!w_wr_full || w_wr_pop);

   assign w_b_dec = w_b_hs && (r_b_cnt != '0);

   assign w_new_err[0] = r_ar_hold && (!axi.arvalid || (w_ar_pl !== r_ar_copy));
   assign w_new_err[1] = r_aw_hold && (!axi.awvalid || (w_aw_pl !== r_aw_copy));
   assign w_new_err[2] = r_w_hold  && (!axi.wvalid  || (w_w_pl  !== r_w_copy));
   assign w_new_err[3] = r_r_hold  && (!axi.rvalid  || (w_r_pl  !== r_r_copy));
   assign w_new_err[4] = r_b_hold  && (!axi.bvalid  || (axi.bresp !== r_b_copy));
   assign w_new_err[5] = w_r_hs && (w_rd_empty || (axi.rlast != w_rd_exp_last));
   assign w_new_err[6] = w_w_hs && (w_wr_empty || (axi.wlast != w_wr_exp_last));
   assign w_new_err[7] = (w_ar_hs && w_rd_full && !w_rd_pop) ||
                         (w_aw_hs && w_wr_full && !w_wr_pop) ||
                         (w_b_hs && (r_b_cnt == '0));
   assign w_any = |w_new_err;

   always_comb begin
      w_first_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (w_new_err[i]) w_first_idx = 3'(i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {r_ar_hold, r_aw_hold, r_w_hold, r_r_hold, r_b_hold} <= '0;
         r_ar_copy <= '0;
         r_aw_copy <= '0;
         r_w_copy  <= '0;
         r_r_copy  <= '0;
         r_b_copy  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_rd_len[i] <= '0;
            r_wr_len[i] <= '0;
         end
         {r_rd_wp, r_rd_rp, r_wr_wp, r_wr_rp} <= '0;
         {r_rd_cnt, r_wr_cnt, r_b_cnt}         <= '0;
         {r_rbeat, r_wbeat}                    <= '0;
         r_err_sticky <= '0;
         r_err_cnt    <= '0;
         r_err_first  <= '0;
         r_err_fv     <= 1'b0;
      end else begin
         r_ar_hold <= axi.arvalid && !axi.arready;
         r_aw_hold <= axi.awvalid && !axi.awready;
         r_w_hold  <= axi.wvalid && !axi.wready;
         r_r_hold  <= axi.rvalid && !axi.rready;
         r_b_hold  <= axi.bvalid && !axi.bready;
         r_ar_copy <= w_ar_pl;
         r_aw_copy <= w_aw_pl;
         r_w_copy  <= w_w_pl;
         r_r_copy  <= w_r_pl;
         r_b_copy  <= axi.bresp;

         if (w_rd_push) begin
            r_rd_len[r_rd_wp] <= axi.arlen;
            r_rd_wp           <= next_ptr(r_rd_wp);
         end
         if (w_rd_pop) r_rd_rp <= next_ptr(r_rd_rp);
         if (w_rd_push && !w_rd_pop)      r_rd_cnt <= r_rd_cnt + CNT_WD'(1);
         else if (!w_rd_push && w_rd_pop) r_rd_cnt <= r_rd_cnt - CNT_WD'(1);
         if (w_rd_pop)                    r_rbeat  <= '0;
         else if (w_r_hs && !w_rd_empty)  r_rbeat  <= r_rbeat + 8'd1;

         if (w_wr_push) begin
            r_wr_len[r_wr_wp] <= axi.awlen;
            r_wr_wp           <= next_ptr(r_wr_wp);
         end
         if (w_wr_pop) r_wr_rp <= next_ptr(r_wr_rp);
         if (w_wr_push && !w_wr_pop)      r_wr_cnt <= r_wr_cnt + CNT_WD'(1);
         else if (!w_wr_push && w_wr_pop) r_wr_cnt <= r_wr_cnt - CNT_WD'(1);
         if (w_wr_pop)                    r_wbeat  <= '0;
         else if (w_w_hs && !w_wr_empty)  r_wbeat  <= r_wbeat + 8'd1;

         // b_pending holds at all-ones rather than wrapping if B falls far behind.
         if (w_wr_pop && !w_b_dec && (r_b_cnt != '1)) r_b_cnt <= r_b_cnt + CNT_WD'(1);
         else if (!w_wr_pop && w_b_dec)               r_b_cnt <= r_b_cnt - CNT_WD'(1);

         if (err_clr) begin
            r_err_sticky <= w_new_err;
            r_err_cnt    <= w_any ? ERR_CNT_WD'(1) : '0;
            r_err_fv     <= w_any;
            r_err_first  <= w_any ? w_first_idx : 3'd0;
         end else begin
            r_err_sticky <= r_err_sticky | w_new_err;
            if (w_any && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_WD'(1);
            if (w_any && !r_err_fv) begin
               r_err_fv    <= 1'b1;
               r_err_first <= w_first_idx;
            end
         end
      end
   end

   assign err_sticky      = r_err_sticky;
   assign err_first_valid = r_err_fv;
   assign err_first       = r_err_first;
   assign err_count       = r_err_cnt;
   assign rd_outstanding  = r_rd_cnt;
   assign wr_outstanding  = r_wr_cnt;
   assign b_pending       = r_b_cnt;
endmodule
